// File: rtl/instr_loader.sv
// Purpose: parses a byte stream (count N, then N hi/lo byte pairs) into instruction-memory writes and holds the CPU in reset until loaded.
// Latency: each write strobes one cycle after its lo-byte transfer; an instruction takes at least 3 cycles.
// Backpressure: in_ready is high only in COUNT/HI/LO; in_valid low simply stalls the parser with no side effects.
module instr_loader #(
    parameter int INSADDR_WIDTH = 8,
    parameter int INS_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [INSADDR_WIDTH-1:0] wr_addr,
    output logic [INS_WIDTH-1:0]     wr_data,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             count_q;
    logic [7:0]             index_q;
    logic [INS_WIDTH-9:0]   hi_q;
    logic [7:0]             lo_q;
    logic                   xfer;

    assign xfer = in_valid & in_ready;

    // Outputs depend on state_q only, so nothing combinational reaches them from the inputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cpu_rst  = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) state_d = COUNT;
            end
            COUNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_d = (in_data == 8'd0) ? DONE : HI;
            end
            HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_d = LO;
            end
            LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_d = WRITE;
            end
            WRITE: begin
                wr_en   = 1'b1;
                busy    = 1'b1;
                state_d = (index_q == count_q - 8'd1) ? DONE : HI;
            end
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_d = COUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            index_q <= 8'd0;
            hi_q    <= '0;
            lo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                COUNT: if (xfer) begin
                    count_q <= in_data;
                    index_q <= 8'd0;
                end
                HI:    if (xfer) hi_q <= in_data[INS_WIDTH-9:0];
                LO:    if (xfer) lo_q <= in_data;
                WRITE: if (state_d == HI) index_q <= index_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign wr_data = {hi_q, lo_q};

    // Narrow memories alias high indices; wide memories see a zero-extended index.
    generate
        if (INSADDR_WIDTH > 8) begin : g_addr_wide
            assign wr_addr = {{(INSADDR_WIDTH-8){1'b0}}, index_q};
        end else if (INSADDR_WIDTH == 8) begin : g_addr_eq
            assign wr_addr = index_q;
        end else begin : g_addr_narrow
            assign wr_addr = index_q[INSADDR_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-count model of the load protocol plus directed streams with literal write expectations.
module tb_instr_loader;

    localparam int AW = 8;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          cpu_rst;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    instr_loader #(.INSADDR_WIDTH(AW), .INS_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = idle, 1 = loading, 2 = loaded; k = bytes consumed in this load.
    int         m_mode = 0;
    int         m_k    = 0;
    int         m_n    = 0;
    int         m_widx = 0;
    bit         m_wp   = 1'b0;
    logic [7:0] m_hi   = 8'd0;
    logic [7:0] m_lo   = 8'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_wp   = 1'b0;
            m_k    = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1;
                m_k    = 0;
                m_wp   = 1'b0;
            end
        end else if (m_wp) begin
            m_wp = 1'b0;
            if (m_k == 2 * m_n + 1) m_mode = 2;
        end else if (in_valid) begin
            if (m_k == 0) begin
                m_n = int'(in_data);
                m_k = 1;
                if (m_n == 0) m_mode = 2;
            end else if (m_k % 2 == 1) begin
                m_hi = in_data;
                m_k++;
            end else begin
                m_lo   = in_data;
                m_k++;
                m_wp   = 1'b1;
                m_widx = (m_k - 3) / 2;
            end
        end
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [11:0] data;
    } wr_rec_t;

    wr_rec_t log_q[$];

    always @(negedge clk) begin
        logic [IW-1:0] exp_data;
        exp_data = {m_hi[IW-9:0], m_lo};
        if (wr_en === 1'b1) log_q.push_back({wr_addr, wr_data});
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (m_mode == 1) && !m_wp});
            check("busy",     {31'd0, busy},     {31'd0, m_mode == 1});
            check("done",     {31'd0, done},     {31'd0, m_mode == 2});
            check("cpu_rst",  {31'd0, cpu_rst},  {31'd0, m_mode != 2});
            check("wr_en",    {31'd0, wr_en},    {31'd0, m_wp});
            if (m_wp) begin
                check("wr_addr", {24'd0, wr_addr}, m_widx);
                check("wr_data", {20'd0, wr_data}, {20'd0, exp_data});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            tries++;
            if (tries > 50) begin
                check("handshake_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[], input int gap);
        foreach (s[i]) send_byte(s[i], gap);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check(name, {31'd0, done}, 32'd1);
        check({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_write(input string name, input int i, input logic [7:0] a, input logic [11:0] d);
        if (i < log_q.size()) begin
            check({name, "_addr"}, {24'd0, log_q[i].addr}, {24'd0, a});
            check({name, "_data"}, {20'd0, log_q[i].data}, {20'd0, d});
        end else begin
            check({name, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] s1[];
        logic [7:0] s2[];
        logic [7:0] s3[];
        logic [7:0] s4[];
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en",    {31'd0, wr_en},    32'd0);
        check("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {20'd0, wr_data},  32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);

        // Basic two-instruction load.
        s1 = '{8'h02, 8'h0A, 8'h15, 8'h0B, 8'hFF};
        log_q.delete();
        pulse_start();
        send_stream(s1, 0);
        wait_done("t1_done");
        check("t1_nwrites", log_q.size(), 2);
        check_write("t1_w0", 0, 8'h00, 12'hA15);
        check_write("t1_w1", 1, 8'h01, 12'hBFF);

        // Empty program: DONE two cycles after start.
        do_reset();
        log_q.delete();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t2_done",    {31'd0, done},    32'd1);
        check("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("t2_busy",    {31'd0, busy},    32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t2_nwrites", log_q.size(), 0);

        // Same stream with 5 idle cycles before every byte.
        do_reset();
        log_q.delete();
        pulse_start();
        send_stream(s1, 5);
        wait_done("t3_done");
        check("t3_nwrites", log_q.size(), 2);
        check_write("t3_w0", 0, 8'h00, 12'hA15);
        check_write("t3_w1", 1, 8'h01, 12'hBFF);

        // Upper hi nibble dropped; start held high mid-load is ignored.
        do_reset();
        log_q.delete();
        s2 = '{8'h01, 8'hF3, 8'h44};
        start = 1'b1;
        @(posedge clk); #1;
        send_stream(s2, 1);
        start = 1'b0;
        wait_done("t4_done");
        check("t4_nwrites", log_q.size(), 1);
        check_write("t4_w0", 0, 8'h00, 12'h344);

        // Reset in LO aborts the load, overriding in_valid.
        do_reset();
        log_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t5_wr_en",    {31'd0, wr_en},    32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5_busy",     {31'd0, busy},     32'd0);
        check("t5_done",     {31'd0, done},     32'd0);
        check("t5_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("t5_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("t5_wr_data",  {20'd0, wr_data},  32'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("t5_nwrites", log_q.size(), 0);

        // Load, then reload from DONE.
        do_reset();
        log_q.delete();
        s3 = '{8'h03, 8'h11, 8'h22, 8'h03, 8'h44, 8'h0F, 8'hC9};
        pulse_start();
        send_stream(s3, 2);
        wait_done("t6_done");
        check("t6_nwrites", log_q.size(), 3);
        check_write("t6_w0", 0, 8'h00, 12'h122);
        check_write("t6_w1", 1, 8'h01, 12'h344);
        check_write("t6_w2", 2, 8'h02, 12'hFC9);
        log_q.delete();
        pulse_start();
        check("t7_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("t7_done",    {31'd0, done},    32'd0);
        check("t7_busy",    {31'd0, busy},    32'd1);
        s4 = '{8'h01, 8'h01, 8'h00};
        send_stream(s4, 0);
        wait_done("t7_redone");
        check("t7_nwrites", log_q.size(), 1);
        check_write("t7_w0", 0, 8'h00, 12'h100);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
